ps2_rx_fifo: RTL
================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver. It replaces fixed three-byte frame capture with a continuous byte stream and checks every frame's start, odd-parity and stop bits. Good bytes are buffered in a first-word-fall-through FIFO with a valid/ready handshake, so the consumer (key decoder / game input logic) reads scan codes one byte at a time at its own pace. It sits between the PS/2 pins and the key-decode logic, in the clk50 domain.

Parameters:
CLK_DIV, 2, sample-tick period in clk50 cycles (>=1); filter and FSM advance only on ticks
FILT_LEN, 8, filter shift-register length in ticks (>=2)
FIFO_DEPTH, 16, FIFO entries; power of two, >=2
TIMEOUT_CYC, 50000, clk50 cycles without a PS/2 falling edge before a partial frame is aborted (used only with PS2_RX_TIMEOUT_EN)

Ports:
clk50  in  1  system clock, 50 MHz; the only clock
reset  in  1  synchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
ps2_dat  in  1  raw PS/2 data pin (asynchronous)
code_data  out  8  FIFO head byte; valid only while code_valid=1
code_valid  out  1  FIFO not empty
code_ready  in  1  consumer accepts head byte when code_valid&code_ready
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
parity_err  out  1  one-cycle pulse: frame dropped, parity bad
frame_err  out  1  one-cycle pulse: frame dropped, stop bit 0
overflow  out  1  one-cycle pulse: good byte dropped, FIFO full
timeout_err  out  1  one-cycle pulse: partial frame aborted

Behaviour:
- Clock and reset: one clock, clk50; reset is synchronous and active-high. No derived clocks; all logic runs on clk50 and uses a tick enable.
- Reset values: all outputs 0 (code_data 0x00); FIFO empty; FSM IDLE. Filter registers and filtered clk/dat are all 1s (bus idle).
- Tick: a counter wraps every CLK_DIV clk50 cycles; tick=1 for one cycle per wrap.
- Filter (per line, on tick): shift the raw pin into a FILT_LEN register. The filtered value goes to 1 when the register is all 1s, goes to 0 when it is all 0s, and otherwise holds. A falling edge is filtered clk going 1->0 between consecutive ticks.
- FSM (evaluated only on a falling-edge tick):
  - IDLE: if dat=0 (start bit), go to DATA with bit_cnt=0. If dat=1, ignore the edge and stay in IDLE.
  - DATA: shift dat into the byte LSB-first and increment bit_cnt. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: if dat=0, pulse frame_err. Else if the ones-count of the 8 data bits plus parity is even, pulse parity_err. Otherwise push the byte. Always return to IDLE.
  - If both stop and parity are bad, only frame_err pulses.
- FIFO:
  - A push in cycle N makes code_valid=1 in cycle N+1 when the FIFO was previously empty.
  - Pop occurs when code_valid&code_ready; code_data shows the next entry in the following cycle.
  - Push while full with no pop in the same cycle: the byte is dropped, overflow pulses, and contents are unchanged.
  - Push and pop in the same cycle while full: both are accepted and fifo_count is unchanged.
  - Push and pop in the same cycle while holding 1 entry: code_valid stays 1 and code_data becomes the new byte.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
  - code_ready while code_valid=0 has no effect.
- Reset mid-frame or mid-FIFO-content: everything clears next cycle and the partial frame is lost. The first falling edge after reset is processed normally.
- Error pulses are mutually exclusive per cycle, except that overflow cannot coincide with a frame error.

Optional Feature:
Macro PS2_RX_TIMEOUT_EN.
- Defined: a counter clears on every filtered falling edge and whenever the FSM is IDLE. If it reaches TIMEOUT_CYC while the FSM is not IDLE, the FSM returns to IDLE, the partial byte is discarded and timeout_err pulses once. The counter saturates and is cleared on return to IDLE.
- Undefined: no counter is built, timeout_err is tied to 0, and the FSM waits indefinitely mid-frame.

Test Plan:
- Common bench setup: CLK_DIV=2, FILT_LEN=8, FIFO_DEPTH=4, ps2_clk half-period 40 clk50 cycles.
- Single byte: send 0x1C, parity 0, stop 1, code_ready=0 -> code_valid=1 one cycle after push; code_data=0x1C, fifo_count=1, no error pulses. Then raise code_ready for 1 cycle -> code_valid=0, fifo_count=0.
- Break sequence: send 0xF0 (parity 1) then 0x1C, code_ready=1 throughout -> consumer receives 0xF0 then 0x1C in order, with no errors.
- Bad frames:
  - 0x1C sent with parity 1 -> parity_err pulses once and the FIFO stays empty.
  - 0xE0 sent with stop bit 0 -> frame_err pulses once and the FIFO stays empty.
- Overflow: with code_ready=0, send 5 good bytes 0x01..0x05 -> fifo_count=4 and overflow pulses on the 5th. Reads then return 0x01..0x04.
- Glitch and reset:
  - A 3-cycle low pulse on ps2_clk -> no edge detected, FSM stays IDLE.
  - Assert reset after the 4th data bit, release, then send 0x2A -> code_data=0x2A with no errors.
- Timeout (PS2_RX_TIMEOUT_EN, TIMEOUT_CYC=1000): stop ps2_clk after the start bit plus 3 data bits -> timeout_err pulses about 1000 cycles after the last edge. A following full 0x1C frame is received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host byte receiver: filtered pins, start/odd-parity/stop checks, FWFT FIFO with valid/ready.
// Byte visible one cycle after its push; when full a new byte is dropped unless popped in the same cycle. Optional abort: PS2_RX_TIMEOUT_EN.
module ps2_rx_fifo #(
    parameter int CLK_DIV     = 2,
    parameter int FILT_LEN    = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          clk50,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_dat,
    output logic [7:0]                    code_data,
    output logic                          code_valid,
    input  logic                          code_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic                          timeout_err
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------- sample tick ----------------
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk50) begin
        if (reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // ---------------- pin synchronisers and glitch filters ----------------
    logic [1:0]          clk_sync_q;
    logic [1:0]          dat_sync_q;
    logic [FILT_LEN-1:0] clk_sr_q;
    logic [FILT_LEN-1:0] clk_sr_d;
    logic [FILT_LEN-1:0] dat_sr_q;
    logic [FILT_LEN-1:0] dat_sr_d;
    logic                clk_f_q;
    logic                clk_f_d;
    logic                dat_f_q;
    logic                dat_f_d;
    logic                fall;

    always_comb begin
        clk_sr_d = clk_sr_q;
        dat_sr_d = dat_sr_q;
        clk_f_d  = clk_f_q;
        dat_f_d  = dat_f_q;
        if (tick) begin
            clk_sr_d = {clk_sr_q[FILT_LEN-2:0], clk_sync_q[1]};
            dat_sr_d = {dat_sr_q[FILT_LEN-2:0], dat_sync_q[1]};
            if (&clk_sr_d) begin
                clk_f_d = 1'b1;
            end else if (~|clk_sr_d) begin
                clk_f_d = 1'b0;
            end
            if (&dat_sr_d) begin
                dat_f_d = 1'b1;
            end else if (~|dat_sr_d) begin
                dat_f_d = 1'b0;
            end
        end
    end

    // The FSM acts in the same cycle the filtered clock drops, using the freshly filtered data.
    assign fall = clk_f_q & ~clk_f_d;

    always_ff @(posedge clk50) begin
        if (reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_sr_q   <= '1;
            dat_sr_q   <= '1;
            clk_f_q    <= 1'b1;
            dat_f_q    <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
            clk_sr_q   <= clk_sr_d;
            dat_sr_q   <= dat_sr_d;
            clk_f_q    <= clk_f_d;
            dat_f_q    <= dat_f_d;
        end
    end

    // ---------------- frame FSM ----------------
    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] byte_q;
    logic       par_q;
    logic       push_q;
    logic [7:0] push_dat_q;
    logic       parity_err_q;
    logic       frame_err_q;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            to_hit;
    logic            timeout_err_q;

    assign to_hit = (state_q != S_IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYC));

    always_ff @(posedge clk50) begin
        if (reset || fall || state_q == S_IDLE) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != TO_W'(TIMEOUT_CYC)) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            byte_q       <= '0;
            par_q        <= 1'b0;
            push_q       <= 1'b0;
            push_dat_q   <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            push_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            if (fall) begin
                case (state_q)
                    S_IDLE: begin
                        if (!dat_f_d) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        byte_q    <= {dat_f_d, byte_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_q   <= dat_f_d;
                        state_q <= S_STOP;
                    end
                    default: begin
                        // A bad stop bit masks a bad parity bit.
                        if (!dat_f_d) begin
                            frame_err_q <= 1'b1;
                        end else if (!(^{byte_q, par_q})) begin
                            parity_err_q <= 1'b1;
                        end else begin
                            push_q     <= 1'b1;
                            push_dat_q <= byte_q;
                        end
                        state_q <= S_IDLE;
                    end
                endcase
`ifdef PS2_RX_TIMEOUT_EN
            end else if (to_hit) begin
                state_q       <= S_IDLE;
                timeout_err_q <= 1'b1;
`endif
            end
        end
    end

    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

    // ---------------- first-word-fall-through FIFO ----------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign code_valid = (count_q != '0);
    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = code_valid & code_ready;
    assign wr_en      = push_q & (~full | pop);

    always_ff @(posedge clk50) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_dat_q;
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push_q & full & ~pop;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign code_data  = code_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule
